// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory between the processor MEM stage (CPU port)
// and an external debug/loader port (EXT port). The CPU owns the memory by
// default and is passed straight through. An EXT request takes the memory for
// exactly one access, freezing the pipeline (cpu_enable low) for its duration.
// A starvation counter forces EXT in after MAX_WAIT cycles of CPU traffic.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   run_en                    global run enable, gates cpu_enable
//   cpu_rd/wr/addr/wdata      CPU MEM-stage request
//   cpu_rdata                 read data back to the CPU (= mem_q)
//   cpu_enable                pipeline enable to the processor
//   ext_req/we/addr/wdata     EXT request (level, held until ext_gnt)
//   ext_gnt                   pulse: EXT access issued this cycle
//   ext_rvalid/ext_rdata      registered EXT read return
//   mem_addr/data/rden/wren   memory-side request
//   mem_q                     memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_en,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_enable,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_rden,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   // wait_cnt only ever reaches MAX_WAIT-1; lat_cnt only READ_LAT-1.
   localparam int WC_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam int LC_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);
   localparam logic [LC_W-1:0] LAT_LOAD  = LC_W'(READ_LAT - 1);

   typedef enum logic [1:0] {
      S_CPU    = 2'd0,
      S_EXT    = 2'd1,
      S_EXT_RD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [LC_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic              ext_rvalid_q, ext_rvalid_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
   logic              cap_we_q, cap_we_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
   logic              cpu_access;

   assign cpu_access = cpu_rd | cpu_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_CPU;
         wait_cnt_q   <= '0;
         lat_cnt_q    <= '0;
         ext_rvalid_q <= 1'b0;
         ext_rdata_q  <= '0;
         cap_we_q     <= 1'b0;
         cap_addr_q   <= '0;
         cap_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         ext_rvalid_q <= ext_rvalid_d;
         ext_rdata_q  <= ext_rdata_d;
         cap_we_q     <= cap_we_d;
         cap_addr_q   <= cap_addr_d;
         cap_wdata_q  <= cap_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      ext_rvalid_d = 1'b0;
      ext_rdata_d  = ext_rdata_q;
      cap_we_d     = cap_we_q;
      cap_addr_d   = cap_addr_q;
      cap_wdata_d  = cap_wdata_q;
      mem_addr     = cpu_addr;
      mem_data     = cpu_wdata;
      mem_rden     = 1'b0;
      mem_wren     = 1'b0;
      cpu_enable   = 1'b0;
      ext_gnt      = 1'b0;

      case (state_q)
         S_CPU: begin
            mem_rden   = cpu_rd;
            mem_wren   = cpu_wr;
            cpu_enable = run_en;
            if (ext_req) begin
               // The CPU access of this cycle still goes through; EXT is
               // captured here and issued on the next cycle.
               if (!cpu_access || (wait_cnt_q == WAIT_LAST)) begin
                  state_d     = S_EXT;
                  cap_we_d    = ext_we;
                  cap_addr_d  = ext_addr;
                  cap_wdata_d = ext_wdata;
                  wait_cnt_d  = '0;
               end else begin
                  wait_cnt_d = wait_cnt_q + WC_W'(1);
               end
            end else begin
               wait_cnt_d = '0;
            end
         end

         S_EXT: begin
            mem_addr = cap_addr_q;
            mem_data = cap_wdata_q;
            mem_wren = cap_we_q;
            mem_rden = !cap_we_q;
            ext_gnt  = 1'b1;
            if (cap_we_q) begin
               state_d = S_CPU;
            end else begin
               lat_cnt_d = LAT_LOAD;
               state_d   = S_EXT_RD;
            end
         end

         S_EXT_RD: begin
            // Keep the read asserted at the same address until data is due.
            mem_addr = cap_addr_q;
            mem_data = cap_wdata_q;
            mem_rden = 1'b1;
            if (lat_cnt_q == '0) begin
               ext_rdata_d  = mem_q;
               ext_rvalid_d = 1'b1;
               state_d      = S_CPU;
            end else begin
               lat_cnt_d = lat_cnt_q - LC_W'(1);
            end
         end

         default: state_d = S_CPU;
      endcase
   end

   assign cpu_rdata  = mem_q;
   assign ext_rvalid = ext_rvalid_q;
   assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter: a synchronous RAM model on the memory port, a
// transaction-level reference model (freeze windows, busy streak, expected
// memory image) checked every cycle, directed scenarios with literal
// expectations, then randomized traffic including random resets.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
   localparam int AW       = 8;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;
   localparam int READ_LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          run_en;
   logic          cpu_rd, cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_enable;
   logic          ext_req, ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic          ext_gnt, ext_rvalid;
   logic [DW-1:0] ext_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_rden, mem_wren;
   logic [DW-1:0] mem_q;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst(rst), .run_en(run_en),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
      .mem_q(mem_q)
   );

   // ---------------- memory attached to the arbiter ----------------
   bit [DW-1:0] ram [256];
   bit [DW-1:0] rd_pipe [READ_LAT];

   always @(posedge clk) begin
      if (mem_wren === 1'b1) ram[mem_addr] <= mem_data;
      if (mem_rden === 1'b1) rd_pipe[0] <= ram[mem_addr];
      for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_q = rd_pipe[READ_LAT-1];

   // ---------------- check bookkeeping ----------------
   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // The model thinks in transactions: a granted EXT access opens a freeze
   // window (1 cycle for a write, 1+READ_LAT for a read), a busy streak counts
   // cycles EXT has waited behind CPU traffic, and ref_mem is the memory image
   // every read must reproduce.
   typedef struct {
      int          due;
      bit [DW-1:0] data;
   } rd_exp_t;

   bit [DW-1:0] ref_mem [256];
   rd_exp_t     rdq[$];
   bit          model_ok = 1'b0;
   bit          frozen   = 1'b0;
   int          fpos     = 0;
   bit          p_we;
   bit [AW-1:0] p_addr;
   bit [DW-1:0] p_wdata;
   int          streak   = 0;
   int          rv_in    = -1;
   bit [DW-1:0] rv_pend;
   bit [DW-1:0] last_rdata = '0;

   logic          e_en, e_gnt, e_rden, e_wren;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;

   always @(negedge clk) begin
      if (model_ok) begin
         if (!frozen) begin
            e_en = run_en; e_gnt = 1'b0; e_rden = cpu_rd; e_wren = cpu_wr;
            e_addr = cpu_addr; e_data = cpu_wdata;
         end else if (fpos == 0) begin
            e_en = 1'b0; e_gnt = 1'b1; e_rden = !p_we; e_wren = p_we;
            e_addr = p_addr; e_data = p_wdata;
         end else begin
            e_en = 1'b0; e_gnt = 1'b0; e_rden = 1'b1; e_wren = 1'b0;
            e_addr = p_addr; e_data = mem_data;
         end
         chk("cpu_enable", cpu_enable, e_en);
         chk("ext_gnt", ext_gnt, e_gnt);
         chk("mem_rden", mem_rden, e_rden);
         chk("mem_wren", mem_wren, e_wren);
         chk("mem_addr", mem_addr, e_addr);
         if (!frozen || fpos == 0) chk("mem_data", mem_data, e_data);
         chk("ext_rvalid", ext_rvalid, (rv_in == 0));
         chk("ext_rdata", ext_rdata, last_rdata);
         if (rdq.size() > 0 && rdq[0].due == 0) begin
            chk("cpu_rdata", cpu_rdata, rdq[0].data);
            void'(rdq.pop_front());
         end
      end

      // memory effects of this cycle happen even if rst is high
      foreach (rdq[i]) rdq[i].due--;
      if (!frozen) begin
         if (cpu_rd === 1'b1) rdq.push_back('{READ_LAT - 1, ref_mem[cpu_addr]});
         if (cpu_wr === 1'b1) ref_mem[cpu_addr] = cpu_wdata;
      end else if (fpos == 0 && p_we) begin
         ref_mem[p_addr] = p_wdata;
      end

      if (rst === 1'b1) begin
         frozen = 1'b0; fpos = 0; streak = 0; rv_in = -1; last_rdata = '0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         if (rv_in == 0) rv_in = -1;
         else if (rv_in > 0) begin
            rv_in--;
            if (rv_in == 0) last_rdata = rv_pend;
         end
         if (frozen) begin
            if (fpos == 0 && !p_we) begin
               rv_in   = READ_LAT;
               rv_pend = ref_mem[p_addr];
            end
            fpos++;
            if (fpos == (p_we ? 1 : 1 + READ_LAT)) begin
               frozen = 1'b0; fpos = 0;
            end
         end else if (ext_req) begin
            if (!(cpu_rd || cpu_wr) || (streak + 1 == MAX_WAIT)) begin
               frozen = 1'b1; fpos = 0;
               p_we = ext_we; p_addr = ext_addr; p_wdata = ext_wdata;
               streak = 0;
            end else begin
               streak++;
            end
         end else begin
            streak = 0;
         end
      end
   end

   // ---------------- directed helpers ----------------
   // Called at posedge+1; raises ext_req and reports grant latency (cycles
   // counted from the request cycle as 1), freeze length, rvalid offset after
   // the grant, and memory-side values in the grant cycle.
   task automatic ext_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input bit cpu_one_shot,
                             output int gnt_n, output int low_n, output int rv_n,
                             output logic [DW-1:0] rv_data,
                             output logic g_wren, output logic [AW-1:0] g_addr);
      int n;
      ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
      gnt_n = 0; low_n = 0; rv_n = -1; rv_data = '0; g_wren = 1'bx; g_addr = 'x;
      n = 0;
      while (gnt_n == 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (ext_gnt === 1'b1) begin
            gnt_n  = n;
            g_wren = mem_wren;
            g_addr = mem_addr;
            if (cpu_enable === 1'b0) low_n = 1;
         end
         @(posedge clk); #1;
         if (cpu_one_shot) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
         if (gnt_n != 0) ext_req = 1'b0;
      end
      ext_req = 1'b0;
      if (gnt_n != 0) begin
         for (int m = 1; m <= 10; m++) begin
            @(negedge clk);
            if (cpu_enable === 1'b0) low_n++;
            if (ext_rvalid === 1'b1 && rv_n < 0) begin rv_n = m; rv_data = ext_rdata; end
            if (cpu_enable === 1'b1) break;
            @(posedge clk); #1;
         end
         @(posedge clk); #1;
      end
   endtask

   int            g_n, l_n, r_n;
   logic [DW-1:0] r_d;
   logic          gw;
   logic [AW-1:0] ga;
   bit            gseen;
   int            tmo;

   initial begin
      rst = 1'b1; run_en = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset then idle
      @(negedge clk);
      chk("idle_cpu_enable", cpu_enable, 1'b1);
      chk("idle_ext_gnt", ext_gnt, 1'b0);
      chk("idle_ext_rvalid", ext_rvalid, 1'b0);
      chk("idle_ext_rdata", ext_rdata, 32'h0);
      chk("idle_mem_wren", mem_wren, 1'b0);
      @(posedge clk); #1 cpu_rd = 1'b1; cpu_addr = 8'h10;
      @(negedge clk);
      chk("cpu_rd_mem_rden", mem_rden, 1'b1);
      chk("cpu_rd_mem_addr", mem_addr, 8'h10);
      @(posedge clk); #1 cpu_rd = 1'b0;

      // EXT write, CPU idle
      ext_access(1'b1, 8'h20, 32'hDEADBEEF, 1'b0, g_n, l_n, r_n, r_d, gw, ga);
      chk("wr_gnt_latency", g_n, 2);
      chk("wr_freeze_len", l_n, 1);
      chk("wr_no_rvalid", r_n, -1);
      chk("wr_gnt_wren", gw, 1'b1);
      chk("wr_gnt_addr", ga, 8'h20);

      // CPU read back of the EXT write
      cpu_rd = 1'b1; cpu_addr = 8'h20;
      @(posedge clk); #1 cpu_rd = 1'b0;
      repeat (READ_LAT - 1) @(posedge clk);
      @(negedge clk);
      chk("cpu_readback", cpu_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;

      // EXT read, CPU idle
      ext_access(1'b0, 8'h20, 32'h0, 1'b0, g_n, l_n, r_n, r_d, gw, ga);
      chk("rd_gnt_latency", g_n, 2);
      chk("rd_freeze_len", l_n, 1 + READ_LAT);
      chk("rd_rvalid_offset", r_n, READ_LAT + 1);
      chk("rd_rdata", r_d, 32'hDEADBEEF);
      chk("rd_gnt_wren", gw, 1'b0);

      // starvation: CPU reads every cycle
      cpu_rd = 1'b1; cpu_addr = 8'h30;
      ext_access(1'b0, 8'h20, 32'h0, 1'b0, g_n, l_n, r_n, r_d, gw, ga);
      chk("starve_gnt_latency", g_n, 5);
      chk("starve_rdata", r_d, 32'hDEADBEEF);
      chk("starve_freeze_len", l_n, 2);
      cpu_rd = 1'b0;

      // CPU write colliding with a new EXT read of the same word
      cpu_wr = 1'b1; cpu_addr = 8'h05; cpu_wdata = 32'h12345678;
      ext_access(1'b0, 8'h05, 32'h0, 1'b1, g_n, l_n, r_n, r_d, gw, ga);
      chk("collide_gnt_latency", g_n, 3);
      chk("collide_no_lost_write", r_d, 32'h12345678);

      // reset while the EXT read is waiting for data
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h20;
      tmo = 0;
      do begin
         @(negedge clk); tmo++;
      end while (ext_gnt !== 1'b1 && tmo < 20);
      if (ext_gnt !== 1'b1) chk("rst_test_gnt_timeout", ext_gnt, 1'b1);
      @(posedge clk); #1 ext_req = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      for (int m = 0; m < 4; m++) begin
         @(negedge clk);
         chk("rst_drop_rvalid", ext_rvalid, 1'b0);
         if (m == 0) begin
            chk("rst_cpu_enable", cpu_enable, 1'b1);
            chk("rst_ext_gnt", ext_gnt, 1'b0);
         end
         @(posedge clk); #1;
      end
      cpu_rd = 1'b1; cpu_addr = 8'h31;
      ext_access(1'b0, 8'h05, 32'h0, 1'b0, g_n, l_n, r_n, r_d, gw, ga);
      chk("post_rst_starve_latency", g_n, 5);
      cpu_rd = 1'b0;

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         gseen = (ext_gnt === 1'b1);
         @(posedge clk); #1;
         rst    = ($urandom_range(0, 299) == 0);
         run_en = ($urandom_range(0, 9) != 0);
         case ($urandom_range(0, 4))
            0, 1: begin cpu_rd = 1'b1; cpu_wr = 1'b0; end
            2:    begin cpu_rd = 1'b0; cpu_wr = 1'b1; end
            default: begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
         endcase
         cpu_addr  = AW'($urandom_range(0, 15));
         cpu_wdata = $urandom;
         if (ext_req && gseen) begin
            ext_req = ($urandom_range(0, 3) == 0);
         end else if (!ext_req && $urandom_range(0, 3) == 0) begin
            ext_req   = 1'b1;
            ext_we    = $urandom_range(0, 1) == 1;
            ext_addr  = AW'($urandom_range(0, 15));
            ext_wdata = $urandom;
         end
      end
      rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ext_req = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
